control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main decoder plus ALU decoder for the 32-bit RISC-V (RV32I + M subset) pipeline.
//  Sits in the decode stage. Maps Op/funct3/funct7 to datapath control signals.
//  Outputs are registered: they form the control half of the ID/EX boundary.
//  Reset flushes the registered controls to a NOP.
// PARAMETERS
//  none
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  rst         in   1  reset; synchronous, active-high; one clock, no other clock domains
//  Op          in   7  instruction opcode, instr[6:0]
//  funct3      in   3  instr[14:12]
//  funct7      in   7  instr[31:25]
//  RegWrite    out  1  write rd in writeback
//  ALUSrc      out  1  1 = ALU operand B is the immediate; 0 = rs2
//  MemWrite    out  1  data-memory write enable
//  ResultSrc   out  1  1 = writeback from memory; 0 = from ALU
//  Branch      out  1  conditional branch instruction
//  ImmSrc      out  2  00 = I-type, 01 = S-type, 10 = B-type
//  ALUControl  out  4  ALU operation, encoding below
// BEHAVIOUR
//  - Decode is combinational. All outputs are registered at posedge clk: latency 1 cycle.
//  - rst=1 at a posedge: every output is 0 (ALUControl=0000, ADD). Reset wins over any input.
//  - Reset mid-stream: the next edge yields the NOP; decode resumes on the first edge after rst falls.
//  - ALUControl encoding:
//      ADD=0000  SUB=0001  AND=0010  OR=0011   XOR=0100  SLT=0101  SLL=0110
//      SRL=0111  SRA=1000  MUL=1001  DIV=1010  REM=1011  SLTU=1100
//  - Main decode, fields listed as RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc, ALU:
//      0000011 load   : 1,1,0,1,0,00,ADD
//      0100011 store  : 0,1,1,0,0,01,ADD
//      1100011 branch : 0,0,0,0,1,10,SUB
//      0010011 op-imm : 1,1,0,0,0,00,ALU from funct3 (I rules)
//      0110011 R-type : 1,0,0,0,0,00,ALU from funct3/funct7 (R rules)
//      any other Op   : all 0, ALU=ADD
//  - R rules when funct7==0000001 (M-extension, exact match):
//      funct3 000 -> MUL; 100 -> DIV; 110 -> REM.
//      Other funct3 values are unsupported: all outputs 0, same as an illegal opcode.
//  - R rules for any other funct7, using funct7[5] as the alt bit:
//      000: alt ? SUB : ADD.  001: SLL.  010: SLT.  011: SLTU.  100: XOR.
//      101: alt ? SRA : SRL (so 0100001 gives SRA).  110: OR.  111: AND.
//  - I rules: same as the R funct3 table, with these differences:
//      000 is always ADD (no SUBI); funct7 is ignored except funct7[5] on 101.
//      M-extension is never decoded.
//  - funct3/funct7 are ignored for load, store, branch and illegal opcodes.
// TESTING
//  - Reset: rst=1 with Op=0110011 -> after the edge, all outputs 0, ALUControl=0000.
//      Release rst -> next edge shows the R-type decode.
//  - Op sweep, 1-cycle latency checked each step:
//      0000011 -> RW1 AS1 MW0 RS1 BR0 Imm00 ADD
//      0100011 -> RW0 AS1 MW1 Imm01 ADD
//      1100011 -> BR1 AS0 Imm10 ALU=0001
//      0010011/f3=000 -> RW1 AS1 ADD
//  - R-type ALU ops, 0110011 with (f3, f7) -> ALUControl:
//      (000,0000000)=0000, (000,0100000)=0001, (000,0000001)=1001, (001,0000000)=0110,
//      (010,0000000)=0101, (100,0000000)=0100, (100,0000001)=1010, (101,0000000)=0111,
//      (101,0100001)=1000, (110,0000000)=0011, (110,0000001)=1011, (111,0000000)=0010.
//  - Illegal/unsupported: Op=1111111 -> all 0;
//      0110011/f3=001/f7=0000001 -> all 0.
//  - Op-imm: f3=101/f7=0100000 -> SRA (1000); f3=000/f7=0100000 -> ADD.
//  - Back-to-back: change Op every cycle -> each output equals the decode of the previous cycle's inputs.

Source files
------------

// File: rtl/control_unit.sv
// Decode-stage main + ALU decoder for the RV32I/M pipeline.
// Controls are computed combinationally and registered into the ID/EX boundary.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic       Branch,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl
);

  localparam int unsigned op_w  = 7;
  localparam int unsigned alu_w = 4;

  localparam logic [op_w-1:0] op_load   = 7'b0000011;
  localparam logic [op_w-1:0] op_store  = 7'b0100011;
  localparam logic [op_w-1:0] op_branch = 7'b1100011;
  localparam logic [op_w-1:0] op_imm    = 7'b0010011;
  localparam logic [op_w-1:0] op_rtype  = 7'b0110011;
  localparam logic [6:0]      f7_mext   = 7'b0000001;

  localparam logic [alu_w-1:0] alu_add  = 4'b0000;
  localparam logic [alu_w-1:0] alu_sub  = 4'b0001;
  localparam logic [alu_w-1:0] alu_and  = 4'b0010;
  localparam logic [alu_w-1:0] alu_or   = 4'b0011;
  localparam logic [alu_w-1:0] alu_xor  = 4'b0100;
  localparam logic [alu_w-1:0] alu_slt  = 4'b0101;
  localparam logic [alu_w-1:0] alu_sll  = 4'b0110;
  localparam logic [alu_w-1:0] alu_srl  = 4'b0111;
  localparam logic [alu_w-1:0] alu_sra  = 4'b1000;
  localparam logic [alu_w-1:0] alu_mul  = 4'b1001;
  localparam logic [alu_w-1:0] alu_div  = 4'b1010;
  localparam logic [alu_w-1:0] alu_rem  = 4'b1011;
  localparam logic [alu_w-1:0] alu_sltu = 4'b1100;

  logic             regwrite_c;
  logic             alusrc_c;
  logic             memwrite_c;
  logic             resultsrc_c;
  logic             branch_c;
  logic [1:0]       immsrc_c;
  logic [alu_w-1:0] alucontrol_c;

  // Shared funct3 table for R and I forms; sub_ok is cleared for op-imm (no SUBI)
  function automatic logic [alu_w-1:0] base_alu(input logic [2:0] f3,
                                                 input logic alt,
                                                 input logic sub_ok);
    logic [alu_w-1:0] r;
    case (f3)
      3'b000:  r = (alt && sub_ok) ? alu_sub : alu_add;
      3'b001:  r = alu_sll;
      3'b010:  r = alu_slt;
      3'b011:  r = alu_sltu;
      3'b100:  r = alu_xor;
      3'b101:  r = alt ? alu_sra : alu_srl;
      3'b110:  r = alu_or;
      default: r = alu_and;
    endcase
    return r;
  endfunction

  // Main decode
  always_comb begin
    regwrite_c   = 1'b0;
    alusrc_c     = 1'b0;
    memwrite_c   = 1'b0;
    resultsrc_c  = 1'b0;
    branch_c     = 1'b0;
    immsrc_c     = 2'b00;
    alucontrol_c = alu_add;
    case (Op)
      op_load: begin
        regwrite_c  = 1'b1;
        alusrc_c    = 1'b1;
        resultsrc_c = 1'b1;
      end
      op_store: begin
        alusrc_c   = 1'b1;
        memwrite_c = 1'b1;
        immsrc_c   = 2'b01;
      end
      op_branch: begin
        branch_c     = 1'b1;
        immsrc_c     = 2'b10;
        alucontrol_c = alu_sub;
      end
      op_imm: begin
        regwrite_c   = 1'b1;
        alusrc_c     = 1'b1;
        alucontrol_c = base_alu(funct3, funct7[5], 1'b0);
      end
      op_rtype: begin
        if (funct7 == f7_mext) begin
          // Only MUL/DIV/REM are supported; other M ops decode as illegal
          case (funct3)
            3'b000: begin
              regwrite_c   = 1'b1;
              alucontrol_c = alu_mul;
            end
            3'b100: begin
              regwrite_c   = 1'b1;
              alucontrol_c = alu_div;
            end
            3'b110: begin
              regwrite_c   = 1'b1;
              alucontrol_c = alu_rem;
            end
            default: alucontrol_c = alu_add;
          endcase
        end else begin
          regwrite_c   = 1'b1;
          alucontrol_c = base_alu(funct3, funct7[5], 1'b1);
        end
      end
      default: alucontrol_c = alu_add;
    endcase
  end

  // ID/EX control register; reset flushes to a NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      ALUSrc     <= 1'b0;
      MemWrite   <= 1'b0;
      ResultSrc  <= 1'b0;
      Branch     <= 1'b0;
      ImmSrc     <= 2'b00;
      ALUControl <= alu_add;
    end else begin
      RegWrite   <= regwrite_c;
      ALUSrc     <= alusrc_c;
      MemWrite   <= memwrite_c;
      ResultSrc  <= resultsrc_c;
      Branch     <= branch_c;
      ImmSrc     <= immsrc_c;
      ALUControl <= alucontrol_c;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, then random stimulus vs a reference model.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RegWrite, ALUSrc, MemWrite, ResultSrc, Branch;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;

  int tests;
  int fails;

  control_unit dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .Branch(Branch), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc, ALUControl}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [10:0] exp;
    string       name;
  } vec_t;

  function automatic logic [10:0] dut_word();
    return {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc, ALUControl};
  endfunction

  // Reference model: straight from the instruction-class rules
  function automatic logic [10:0] ref_decode(input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
    logic [3:0] tab [8];
    logic [3:0] alu;
    tab[0] = 4'd0;  tab[1] = 4'd6;  tab[2] = 4'd5; tab[3] = 4'd12;
    tab[4] = 4'd4;  tab[5] = 4'd7;  tab[6] = 4'd3; tab[7] = 4'd2;
    alu = tab[f3];
    if (f3 == 3'd5 && f7[5]) alu = 4'd8;
    if (op == 7'b0000011) return 11'b11010_00_0000;
    if (op == 7'b0100011) return 11'b01100_01_0000;
    if (op == 7'b1100011) return 11'b00001_10_0001;
    if (op == 7'b0010011) return {7'b11000_00, alu};
    if (op == 7'b0110011) begin
      if (f7 == 7'b0000001) begin
        if (f3 == 3'd0) return 11'b10000_00_1001;
        if (f3 == 3'd4) return 11'b10000_00_1010;
        if (f3 == 3'd6) return 11'b10000_00_1011;
        return 11'd0;
      end
      if (f3 == 3'd0 && f7[5]) alu = 4'd1;
      return {7'b10000_00, alu};
    end
    return 11'd0;
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = dut_word();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [6:0] o,
                       input logic [2:0] f3, input logic [6:0] f7);
    rst    = r;
    Op     = o;
    funct3 = f3;
    funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [$];

  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [10:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    Op     = '0;
    funct3 = '0;
    funct7 = '0;

    // Consecutive entries change inputs every cycle (back-to-back decode)
    vecs.push_back(mk(1, 7'b0110011, 3'b000, 7'b0100000, 11'd0,            "reset_rtype"));
    vecs.push_back(mk(0, 7'b0110011, 3'b000, 7'b0100000, 11'b10000_00_0001, "release_sub"));
    vecs.push_back(mk(0, 7'b0000011, 3'b111, 7'b1111111, 11'b11010_00_0000, "load"));
    vecs.push_back(mk(0, 7'b0100011, 3'b010, 7'b0100000, 11'b01100_01_0000, "store"));
    vecs.push_back(mk(0, 7'b1100011, 3'b001, 7'b0000001, 11'b00001_10_0001, "branch"));
    vecs.push_back(mk(0, 7'b0010011, 3'b000, 7'b0000000, 11'b11000_00_0000, "addi"));
    vecs.push_back(mk(0, 7'b0110011, 3'b000, 7'b0000000, 11'b10000_00_0000, "r_add"));
    vecs.push_back(mk(0, 7'b0110011, 3'b000, 7'b0000001, 11'b10000_00_1001, "r_mul"));
    vecs.push_back(mk(0, 7'b0110011, 3'b001, 7'b0000000, 11'b10000_00_0110, "r_sll"));
    vecs.push_back(mk(0, 7'b0110011, 3'b010, 7'b0000000, 11'b10000_00_0101, "r_slt"));
    vecs.push_back(mk(0, 7'b0110011, 3'b011, 7'b0000000, 11'b10000_00_1100, "r_sltu"));
    vecs.push_back(mk(0, 7'b0110011, 3'b100, 7'b0000000, 11'b10000_00_0100, "r_xor"));
    vecs.push_back(mk(0, 7'b0110011, 3'b100, 7'b0000001, 11'b10000_00_1010, "r_div"));
    vecs.push_back(mk(0, 7'b0110011, 3'b101, 7'b0000000, 11'b10000_00_0111, "r_srl"));
    vecs.push_back(mk(0, 7'b0110011, 3'b101, 7'b0100001, 11'b10000_00_1000, "r_sra"));
    vecs.push_back(mk(0, 7'b0110011, 3'b110, 7'b0000000, 11'b10000_00_0011, "r_or"));
    vecs.push_back(mk(0, 7'b0110011, 3'b110, 7'b0000001, 11'b10000_00_1011, "r_rem"));
    vecs.push_back(mk(0, 7'b0110011, 3'b111, 7'b0000000, 11'b10000_00_0010, "r_and"));
    vecs.push_back(mk(0, 7'b1111111, 3'b000, 7'b0000000, 11'd0,            "illegal_op"));
    vecs.push_back(mk(0, 7'b0110011, 3'b001, 7'b0000001, 11'd0,            "m_unsupported"));
    vecs.push_back(mk(0, 7'b0010011, 3'b101, 7'b0100000, 11'b11000_00_1000, "srai"));
    vecs.push_back(mk(0, 7'b0010011, 3'b000, 7'b0100000, 11'b11000_00_0000, "addi_no_sub"));
    vecs.push_back(mk(0, 7'b0010011, 3'b000, 7'b0000001, 11'b11000_00_0000, "addi_no_mul"));
    // Mid-stream reset: NOP on the reset edge, decode resumes right after
    vecs.push_back(mk(0, 7'b0000011, 3'b000, 7'b0000000, 11'b11010_00_0000, "pre_reset_load"));
    vecs.push_back(mk(1, 7'b0100011, 3'b000, 7'b0000000, 11'd0,            "midstream_reset"));
    vecs.push_back(mk(0, 7'b0100011, 3'b000, 7'b0000000, 11'b01100_01_0000, "resume_store"));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7);
      check(vecs[i].name, vecs[i].exp);
    end

    // Random stream against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [6:0]  ops [6];
      logic [6:0]  f7s [5];
      logic        r;
      logic [6:0]  o;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [10:0] e;
      ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b1100011;
      ops[3] = 7'b0010011; ops[4] = 7'b0110011; ops[5] = 7'($urandom);
      f7s[0] = 7'b0000000; f7s[1] = 7'b0100000; f7s[2] = 7'b0000001;
      f7s[3] = 7'b0100001; f7s[4] = 7'($urandom);
      r  = ($urandom_range(0, 15) == 0);
      o  = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      f7 = f7s[$urandom_range(0, 4)];
      e  = r ? 11'd0 : ref_decode(o, f3, f7);
      apply(r, o, f3, f7);
      check("random", e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
